// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   Simplified AXI4 responder backed by an on-chip SRAM. It serves one
//   transaction at a time and supports INCR bursts only. It stands in for a
//   DDR subsystem when an AXI master's traffic generator and checker are
//   being brought up.
//
// Ports
//   core_clk, core_rstn_sync   : clock and asynchronous active-low reset
//   aw*   (awvalid/awready/awaddr/awlen) : write address channel
//   w*    (wvalid/wready/wlast/wdata)    : write data channel
//   b*    (bvalid/bready)                : write response channel
//   ar*   (arvalid/arready/araddr/arlen) : read address channel
//   r*    (rvalid/rready/rlast/rdata)    : read data channel
//   proto_err                            : sticky wlast-disagreement flag
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where both valid and ready are high. A source holds valid and its
// payload stable until that transfer. All ready/valid outputs here come
// straight from flops.
//
// Debug: the FSM state is held in state_q (type state_e) so checkers can
// bind to it by hierarchical reference.

module axi_sram_slave #(
  parameter int DQ_LEVEL  = 1,
  parameter int ADDR_BITS = 25,
  parameter int MEM_BITS  = 10
) (
  input  logic                      core_clk,
  input  logic                      core_rstn_sync,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_BITS-1:0]      awaddr,
  input  logic [7:0]                awlen,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      wlast,
  input  logic [(8<<DQ_LEVEL)-1:0]  wdata,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_BITS-1:0]      araddr,
  input  logic [7:0]                arlen,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      rlast,
  output logic [(8<<DQ_LEVEL)-1:0]  rdata,
  output logic                      proto_err
);

  localparam int DATA_BITS = 8 << DQ_LEVEL;
  localparam int DEPTH     = 1 << MEM_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    WRESP = 3'd2,
    RPRE  = 3'd3,
    RDATA = 3'd4
  } state_e;

  state_e                 state_q;
  logic [MEM_BITS-1:0]    idx_q;
  logic [7:0]             len_q;
  logic [7:0]             cnt_q;
  logic                   awready_q;
  logic                   arready_q;
  logic                   wready_q;
  logic                   bvalid_q;
  logic                   rvalid_q;
  logic                   rlast_q;
  logic [DATA_BITS-1:0]   rdata_q;
  logic                   proto_err_q;

  // Backing store: never reset, contents survive core_rstn_sync.
  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic                   aw_hs;
  logic                   ar_hs;
  logic                   w_hs;
  logic                   b_hs;
  logic                   r_hs;
  logic                   final_beat;
  logic [MEM_BITS-1:0]    idx_inc;
  logic [MEM_BITS-1:0]    aw_idx;
  logic [MEM_BITS-1:0]    ar_idx;
  logic                   unused_addr_bits;

  // Word index: drop the byte-lane bits, ignore anything above the SRAM.
  assign aw_idx  = awaddr[MEM_BITS+DQ_LEVEL-1:DQ_LEVEL];
  assign ar_idx  = araddr[MEM_BITS+DQ_LEVEL-1:DQ_LEVEL];
  assign unused_addr_bits = ^{awaddr, araddr};

  // Write wins when both address channels are valid in IDLE.
  assign aw_hs      = awvalid & awready_q;
  assign ar_hs      = arvalid & arready_q & ~awvalid;
  assign w_hs       = wvalid & wready_q;
  assign b_hs       = bvalid_q & bready;
  assign r_hs       = rvalid_q & rready;
  assign final_beat = (cnt_q == len_q);
  // Increment wraps modulo the SRAM depth.
  assign idx_inc    = idx_q + MEM_BITS'(1);

  always_ff @(posedge core_clk) begin
    if (w_hs) begin
      mem[idx_q] <= wdata;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn_sync) begin
    if (!core_rstn_sync) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Address readies rise one cycle after reset release, then stay
          // up for as long as the FSM idles.
          awready_q <= 1'b1;
          arready_q <= 1'b1;
          if (aw_hs) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b1;
            idx_q     <= aw_idx;
            len_q     <= awlen;
            cnt_q     <= '0;
            state_q   <= WDATA;
          end else if (ar_hs) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            idx_q     <= ar_idx;
            len_q     <= arlen;
            cnt_q     <= '0;
            state_q   <= RPRE;
          end
        end

        WDATA: begin
          if (w_hs) begin
            // The beat count ends the burst; wlast is only cross-checked.
            if (wlast != final_beat) begin
              proto_err_q <= 1'b1;
            end
            idx_q <= idx_inc;
            cnt_q <= cnt_q + 8'd1;
            if (final_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              state_q  <= WRESP;
            end
          end
        end

        WRESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            arready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        RPRE: begin
          // SRAM read of the first beat; its output register is rdata.
          rdata_q  <= mem[idx_q];
          rlast_q  <= (len_q == 8'd0);
          rvalid_q <= 1'b1;
          state_q  <= RDATA;
        end

        RDATA: begin
          // Without a handshake nothing changes, so the beat is held.
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              awready_q <= 1'b1;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              // Fetch the next beat so data streams at one beat per cycle.
              rdata_q <= mem[idx_inc];
              idx_q   <= idx_inc;
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign awready   = awready_q;
  assign arready   = arready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rdata     = rdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave with default parameters
//   (16-bit data, 1024-word SRAM). A reference memory tracks every
//   completed write beat. Read bursts push their expected beats onto exp_q
//   when the address is issued. Each returned beat pops one entry and is
//   compared against it.

module tb_axi_sram_slave;

  localparam int DQ_LEVEL  = 1;
  localparam int ADDR_BITS = 25;
  localparam int MEM_BITS  = 10;
  localparam int DW        = 16;
  localparam int DEPTH     = 1024;
  localparam int TMO       = 200;

  logic                 clk;
  logic                 rst_n;
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_BITS-1:0] awaddr;
  logic [7:0]           awlen;
  logic                 wvalid;
  logic                 wready;
  logic                 wlast;
  logic [DW-1:0]        wdata;
  logic                 bvalid;
  logic                 bready;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_BITS-1:0] araddr;
  logic [7:0]           arlen;
  logic                 rvalid;
  logic                 rready;
  logic                 rlast;
  logic [DW-1:0]        rdata;
  logic                 proto_err;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf [256];
  int vectors;
  int miscompares;

  axi_sram_slave #(
    .DQ_LEVEL (DQ_LEVEL),
    .ADDR_BITS(ADDR_BITS),
    .MEM_BITS (MEM_BITS)
  ) dut (
    .core_clk      (clk),
    .core_rstn_sync(rst_n),
    .awvalid       (awvalid),
    .awready       (awready),
    .awaddr        (awaddr),
    .awlen         (awlen),
    .wvalid        (wvalid),
    .wready        (wready),
    .wlast         (wlast),
    .wdata         (wdata),
    .bvalid        (bvalid),
    .bready        (bready),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .arlen         (arlen),
    .rvalid        (rvalid),
    .rready        (rready),
    .rlast         (rlast),
    .rdata         (rdata),
    .proto_err     (proto_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Write burst of len+1 beats from wbuf, starting at word idx.
  // bad_last: beat whose wlast is inverted (-1 none).
  // abort_at: stop driving after this many beats (-1 run to completion).
  task automatic write_burst(input int idx, input int len, input int bad_last,
                             input int abort_at);
    int t;
    int beat;
    int cycles;
    @(posedge clk); #1;
    awvalid = 1'b1;
    awaddr  = ADDR_BITS'(idx << 1);
    awlen   = 8'(len);
    t = 0;
    while (awready !== 1'b1 && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    vectors++;
    if (t >= TMO) begin
      miscompares++;
      $display("FAIL aw_wait: awready=%b want 1 within %0d cycles", awready, TMO);
      awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b1;
    beat    = 0;
    cycles  = 0;
    while (beat <= len && beat != abort_at && cycles < TMO) begin
      wdata = wbuf[beat];
      wlast = (beat == len) ^ (beat == bad_last);
      if (wready === 1'b1) begin
        ref_mem[(idx + beat) % DEPTH] = wbuf[beat];
        beat++;
      end
      cycles++;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (abort_at >= 0) return;
    vectors++;
    if (cycles != len + 1) begin
      miscompares++;
      $display("FAIL w_throughput: %0d cycles for %0d beats want %0d", cycles, len + 1, len + 1);
    end
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL b_latency: bvalid=%b one cycle after last w want 1", bvalid);
    end
    bready = 1'b1;
    t = 0;
    while (bvalid !== 1'b1 && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    bready = 1'b0;
    vectors++;
    if ({bvalid, awready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b_done: bvalid,awready=%b want 01", {bvalid, awready});
    end
  endtask

  // Read burst; mode 0 holds rready high, mode 1 toggles 1,0,0,1,0,0...
  // junk is ORed into the byte address (ignored bits).
  task automatic read_burst(input int idx, input int len, input int mode,
                            input int junk);
    int t;
    int beat;
    int k;
    logic stalled;
    logic [DW-1:0] held_d;
    logic held_l;
    logic [DW-1:0] exp;
    for (int b = 0; b <= len; b++) exp_q.push_back(ref_mem[(idx + b) % DEPTH]);
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = ADDR_BITS'((idx << 1) | junk);
    arlen   = 8'(len);
    t = 0;
    while (arready !== 1'b1 && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    vectors++;
    if (t >= TMO) begin
      miscompares++;
      $display("FAIL ar_wait: arready=%b want 1 within %0d cycles", arready, TMO);
      arvalid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL r_latency_early: rvalid=%b one cycle after AR want 0", rvalid);
    end
    @(posedge clk); #1;
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency: rvalid=%b two cycles after AR want 1", rvalid);
    end
    beat    = 0;
    k       = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    while (beat <= len && k < TMO * 4) begin
      rready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (stalled) begin
        vectors++;
        if ({rvalid, rlast, rdata} !== {1'b1, held_l, held_d}) begin
          miscompares++;
          $display("FAIL r_hold: beat %0d got v=%b l=%b d=%h want v=1 l=%b d=%h",
                   beat, rvalid, rlast, rdata, held_l, held_d);
        end
      end
      if (rvalid === 1'b1 && rready) begin
        exp = exp_q.pop_front();
        vectors++;
        if (rdata !== exp) begin
          miscompares++;
          $display("FAIL r_data: beat %0d got %h want %h", beat, rdata, exp);
        end
        vectors++;
        if (rlast !== (beat == len)) begin
          miscompares++;
          $display("FAIL r_last: beat %0d got %b want %b", beat, rlast, (beat == len));
        end
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = (rvalid === 1'b1);
        held_d  = rdata;
        held_l  = rlast;
      end
      k++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (beat <= len) begin
      vectors++;
      miscompares++;
      $display("FAIL r_timeout: got %0d beats want %0d", beat, len + 1);
      exp_q.delete();
    end
    if (mode == 0) begin
      vectors++;
      if (k != len + 1) begin
        miscompares++;
        $display("FAIL r_throughput: %0d cycles for %0d beats want %0d", k, len + 1, len + 1);
      end
    end
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL r_done: rvalid=%b after last beat want 0", rvalid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, rdata, proto_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all 0",
               {awready, wready, bvalid, arready, rvalid, rlast, rdata, proto_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("FAIL idle_ready: awready,arready=%b want 11", {awready, arready});
    end
  endtask

  task automatic test_single_beat();
    wbuf[0] = 16'hA5A5;
    write_burst(8, 0, -1, -1);
    read_burst(8, 0, 0, 32'h0000_8001);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) wbuf[i] = DW'(i);
    write_burst(0, 7, -1, -1);
    read_burst(0, 7, 0, 0);
  endtask

  task automatic test_backpressure();
    read_burst(0, 7, 1, 0);
  endtask

  task automatic test_arbitration();
    int t;
    logic [DW-1:0] exp;
    @(posedge clk); #1;
    awvalid = 1'b1;
    arvalid = 1'b1;
    awaddr  = ADDR_BITS'(300 << 1);
    araddr  = ADDR_BITS'(300 << 1);
    awlen   = 8'd0;
    arlen   = 8'd0;
    t = 0;
    while (awready !== 1'b1 && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    vectors++;
    if ({wready, arready} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb_aw_first: wready,arready=%b want 10", {wready, arready});
    end
    wvalid = 1'b1;
    wlast  = 1'b1;
    wdata  = 16'h3C5A;
    ref_mem[300] = 16'h3C5A;
    @(posedge clk); #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
    vectors++;
    if ({bvalid, arready} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb_wresp: bvalid,arready=%b want 10", {bvalid, arready});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL arb_ar_after_b: arready=%b want 1", arready);
    end
    exp_q.push_back(ref_mem[300]);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    t = 0;
    while (rvalid !== 1'b1 && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    exp = exp_q.pop_front();
    vectors++;
    if ({rvalid, rlast, rdata} !== {1'b1, 1'b1, exp}) begin
      miscompares++;
      $display("FAIL arb_read: v=%b l=%b d=%h want v=1 l=1 d=%h", rvalid, rlast, rdata, exp);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_wrap_and_error();
    for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom_range(0, 65535));
    write_burst(1022, 3, -1, -1);
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean: proto_err=%b want 0", proto_err);
    end
    read_burst(1022, 3, 0, 0);
    read_burst(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom_range(0, 65535));
    write_burst(200, 3, 1, -1);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_early_last: proto_err=%b want 1", proto_err);
    end
    read_burst(200, 3, 0, 0);
    write_burst(400, 1, -1, -1);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: proto_err=%b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) wbuf[i] = DW'(16'h5000 + i * 16'h0111);
    write_burst(500, 7, -1, 4);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, rdata, proto_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %b want all 0",
               {awready, wready, bvalid, arready, rvalid, rlast, rdata, proto_err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_burst(500, 3, 0, 0);
    for (int i = 0; i < 6; i++) wbuf[i] = DW'($urandom_range(0, 65535));
    write_burst(700, 5, -1, -1);
    read_burst(700, 5, 1, 0);
  endtask

  task automatic test_missing_last();
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pre: proto_err=%b want 0", proto_err);
    end
    for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom_range(0, 65535));
    write_burst(800, 2, 2, -1);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_missing_last: proto_err=%b want 1", proto_err);
    end
    read_burst(800, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      int base;
      int len;
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) wbuf[i] = DW'($urandom_range(0, 65535));
      write_burst(base, len, -1, -1);
      read_burst(base, len, n % 2, 0);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    awvalid = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    wdata   = '0;
    bready  = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    arlen   = '0;
    rready  = 1'b0;

    test_reset();
    test_single_beat();
    test_burst();
    test_backpressure();
    test_arbitration();
    test_wrap_and_error();
    test_reset_mid();
    test_missing_last();
    test_back_to_back();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4-subset responder (target) with on-chip SRAM backing store.
- Uses the same simplified AXI port set that mbist_axi_master drives: aw/w/b/ar/r, no id, size, strb or resp.
- Replaces ddr_top in block-level benches and MBIST bring-up, so the master's traffic generator and checker can be qualified without the DDR controller or device model.
- Serves one transaction at a time. INCR bursts only.

Parameters:
- DQ_LEVEL, 1, data width selector; DATA_BITS = 8<<DQ_LEVEL.
- ADDR_BITS, 25, width of awaddr/araddr (byte address).
- MEM_BITS, 10, log2 of SRAM depth in DATA_BITS-wide words.

Ports:
- core_clk  in  1  single clock for all logic.
- core_rstn_sync  in  1  asynchronous active-low reset.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awaddr  in  ADDR_BITS  write start byte address.
- awlen  in  8  write beats minus 1.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wlast  in  1  last write beat marker.
- wdata  in  DATA_BITS  write data.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  ADDR_BITS  read start byte address.
- arlen  in  8  read beats minus 1.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rlast  out  1  last read beat.
- rdata  out  DATA_BITS  read data.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Clock and reset: one clock, core_clk. Reset core_rstn_sync is asynchronous and active-low.
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, proto_err=0. FSM returns to IDLE.
- SRAM contents are not reset and are retained across reset.
- Word index = addr[MEM_BITS+DQ_LEVEL-1:DQ_LEVEL]. Lower DQ_LEVEL bits and bits above the index are ignored.
- Address increments by 1 word per beat, modulo 2^MEM_BITS (wraps silently to word 0). Beats per burst = len+1, range 1..256.
- FSM states: IDLE, WDATA, WRESP, RPRE, RDATA.
- IDLE:
  - awready=1 and arready=1 only in IDLE.
  - If awvalid, accept AW (ar is not accepted that cycle) and go to WDATA. Write has priority when awvalid and arvalid are both high.
  - Else if arvalid, accept AR and go to RPRE.
  - Latch start index and len on accept.
- WDATA:
  - wready=1 in every WDATA cycle, starting the cycle after the AW handshake.
  - On each w handshake, write wdata to mem[index], increment index, increment beat counter.
  - On the final counted beat (count==len), go to WRESP.
  - wlast disagreement sets proto_err: wlast=1 on a non-final beat, or wlast=0 on the final beat. Beat count alone ends the burst.
- WRESP:
  - bvalid=1 from the cycle after the final w handshake; held until bready.
  - On the b handshake, go to IDLE. awready returns high the next cycle.
- RPRE:
  - Single cycle: issues the SRAM read of the start index, then go to RDATA.
  - First rvalid appears 2 cycles after the AR handshake.
- RDATA:
  - rvalid=1 and rdata = registered SRAM output.
  - SRAM read address is the next-beat index when the r handshake occurs, else the current index. This gives 1 beat/cycle with rready held high.
  - With rready=0, rdata, rlast and rvalid are held stable.
  - rlast=1 exactly when beat counter == len.
  - On the handshake with rlast=1, go to IDLE. rvalid drops the next cycle.
- Write-then-read ordering: a read of a location written by a completed burst (bvalid already handshaken) returns the new data.
- Ignored inputs:
  - wvalid outside WDATA and bready outside WRESP are ignored.
  - rready without rvalid has no effect.
- proto_err is set only as described under WDATA and clears only on reset.
- Reset asserted mid-burst: the burst is aborted immediately and all outputs take their reset values. Beats already written remain in SRAM.

Test Plan:
- Single beat: AW addr 0x10 (DQ_LEVEL=1, index 8), len 0, wdata 0xA5A5, then AR same -> bvalid 1 cycle after the w beat; rvalid 2 cycles after the AR handshake; rdata 0xA5A5, rlast=1.
- Burst: write len 7 at index 0 with data 0..7, rready held 1 -> wready for 8 consecutive cycles. Read returns 0..7 on 8 consecutive cycles, rlast only on beat 8.
- Backpressure: 8-beat read with rready toggling 1,0,0,1,... -> each beat held stable while rready=0; sequence 0..7 with no drops or repeats.
- Arbitration: awvalid and arvalid both high in IDLE -> AW accepted first, arready=0 until the b handshake, then the read completes with the freshly written data.
- Wrap and error: write len 3 starting at index 1022 (MEM_BITS=10) -> data lands at 1022, 1023, 0, 1. A separate burst with wlast on beat 2 of len 3 sets proto_err=1, which stays set.
- Reset mid-operation: assert reset at beat 4 of an 8-beat write -> all outputs 0, proto_err 0. Beats 0..3 read back correctly after reset; a new burst is accepted normally.
